lcd_ctrl_param: RTL and testbench

LCD_CTRL_PARAM -- requirements
Module: lcd_ctrl_param

---
 rtl/lcd_ctrl_pkg.sv | 25 ++
 rtl/lcd_win_alu.sv | 51 +++++
 rtl/lcd_ctrl_param.sv | 162 ++++++++++++++++
 tb/tb_lcd_ctrl_param.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_ctrl_pkg.sv
// Shared command codes and controller state encoding for the LCD window-processing controller.
package lcd_ctrl_pkg;

    localparam logic [3:0] CMD_WRITE = 4'd0;
    localparam logic [3:0] CMD_UP    = 4'd1;
    localparam logic [3:0] CMD_DOWN  = 4'd2;
    localparam logic [3:0] CMD_LEFT  = 4'd3;
    localparam logic [3:0] CMD_RIGHT = 4'd4;
    localparam logic [3:0] CMD_MAX   = 4'd5;
    localparam logic [3:0] CMD_MIN   = 4'd6;
    localparam logic [3:0] CMD_AVG   = 4'd7;
    localparam logic [3:0] CMD_CCW   = 4'd8;
    localparam logic [3:0] CMD_CW    = 4'd9;
    localparam logic [3:0] CMD_MIRX  = 4'd10;
    localparam logic [3:0] CMD_MIRY  = 4'd11;

    typedef enum logic [2:0] {
        ST_LOAD  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_OP    = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/lcd_win_alu.sv
// Combinational 2x2 window operator: returns the new a,b,c,d pixels for a command code.
module lcd_win_alu
    import lcd_ctrl_pkg::*;
#(
    parameter int PIX_W = 8
) (
    input  logic [PIX_W-1:0] a,
    input  logic [PIX_W-1:0] b,
    input  logic [PIX_W-1:0] c,
    input  logic [PIX_W-1:0] d,
    input  logic [3:0]       cmd,
    output logic [PIX_W-1:0] na,
    output logic [PIX_W-1:0] nb,
    output logic [PIX_W-1:0] nc,
    output logic [PIX_W-1:0] nd
);

    function automatic logic [PIX_W-1:0] max2(input logic [PIX_W-1:0] x, input logic [PIX_W-1:0] y);
        return (x > y) ? x : y;
    endfunction

    function automatic logic [PIX_W-1:0] min2(input logic [PIX_W-1:0] x, input logic [PIX_W-1:0] y);
        return (x < y) ? x : y;
    endfunction

    logic [PIX_W+1:0] sum;
    logic [PIX_W-1:0] mx, mn, avg;

    always_comb begin
        // Two guard bits hold four full-scale pixels without wrapping
        sum = {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};
        avg = sum[PIX_W+1:2];
        mx  = max2(max2(a, b), max2(c, d));
        mn  = min2(min2(a, b), min2(c, d));
        na  = a;
        nb  = b;
        nc  = c;
        nd  = d;
        case (cmd)
            CMD_MAX:  begin na = mx;  nb = mx;  nc = mx;  nd = mx;  end
            CMD_MIN:  begin na = mn;  nb = mn;  nc = mn;  nd = mn;  end
            CMD_AVG:  begin na = avg; nb = avg; nc = avg; nd = avg; end
            CMD_CCW:  begin na = b;   nb = d;   nc = a;   nd = c;   end
            CMD_CW:   begin na = c;   nb = a;   nc = d;   nd = b;   end
            CMD_MIRX: begin na = c;   nb = d;   nc = a;   nd = b;   end
            CMD_MIRY: begin na = b;   nb = a;   nc = d;   nd = c;   end
            default:  ;
        endcase
    end

endmodule

// File: rtl/lcd_ctrl_param.sv
// Frame controller: loads an image from ROM, applies 2x2 window commands, then streams the
// processed frame to RAM before starting the next frame.
module lcd_ctrl_param
    import lcd_ctrl_pkg::*;
#(
    parameter  int IMG_W = 8,
    parameter  int IMG_H = 8,
    parameter  int PIX_W = 8,
    localparam int N     = IMG_W * IMG_H,
    localparam int AW    = $clog2(N)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       cmd,
    input  logic             cmd_valid,
    input  logic [PIX_W-1:0] IROM_Q,
    output logic             IROM_rd,
    output logic [AW-1:0]    IROM_A,
    output logic             IRAM_valid,
    output logic [PIX_W-1:0] IRAM_D,
    output logic [AW-1:0]    IRAM_A,
    output logic             busy,
    output logic             done
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam logic [XW-1:0] WX0    = XW'(IMG_W / 2 - 1);
    localparam logic [YW-1:0] WY0    = YW'(IMG_H / 2 - 1);
    localparam logic [XW-1:0] WX_MAX = XW'(IMG_W - 2);
    localparam logic [YW-1:0] WY_MAX = YW'(IMG_H - 2);
    localparam logic [AW-1:0] LAST   = AW'(N - 1);

    state_t          state;
    logic [3:0]      cmd_r;
    logic [XW-1:0]   wx;
    logic [YW-1:0]   wy;
    logic            cap_vld;
    logic [AW-1:0]   cap_a;
    logic [PIX_W-1:0] pix_buf [N];
    logic [AW-1:0]   idx_a, idx_b, idx_c, idx_d;
    logic [PIX_W-1:0] na, nb, nc, nd;

    assign idx_a = AW'(int'(wy) * IMG_W + int'(wx));
    assign idx_b = idx_a + AW'(1);
    assign idx_c = idx_a + AW'(IMG_W);
    assign idx_d = idx_c + AW'(1);

    lcd_win_alu #(.PIX_W(PIX_W)) u_alu (
        .a   (pix_buf[idx_a]),
        .b   (pix_buf[idx_b]),
        .c   (pix_buf[idx_c]),
        .d   (pix_buf[idx_d]),
        .cmd (cmd_r),
        .na  (na),
        .nb  (nb),
        .nc  (nc),
        .nd  (nd)
    );

    // Frame buffer carries no reset; every frame is fully reloaded before use
    always_ff @(posedge clk) begin
        if (state == ST_LOAD && cap_vld) begin
            pix_buf[cap_a] <= IROM_Q;
        end else if (state == ST_OP) begin
            pix_buf[idx_a] <= na;
            pix_buf[idx_b] <= nb;
            pix_buf[idx_c] <= nc;
            pix_buf[idx_d] <= nd;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_LOAD;
            cmd_r      <= '0;
            wx         <= WX0;
            wy         <= WY0;
            cap_vld    <= 1'b0;
            cap_a      <= '0;
            IROM_rd    <= 1'b0;
            IROM_A     <= '0;
            IRAM_valid <= 1'b0;
            IRAM_D     <= '0;
            IRAM_A     <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
        end else begin
            case (state)
                ST_LOAD: begin
                    // ROM data trails its address by one cycle, so capture uses a delayed copy
                    cap_vld <= IROM_rd;
                    cap_a   <= IROM_A;
                    if (IROM_rd) begin
                        if (IROM_A == LAST) IROM_rd <= 1'b0;
                        else                IROM_A  <= IROM_A + AW'(1);
                    end else if (!cap_vld) begin
                        IROM_rd <= 1'b1;
                        IROM_A  <= '0;
                    end
                    if (cap_vld && cap_a == LAST) begin
                        state   <= ST_IDLE;
                        busy    <= 1'b0;
                        cap_vld <= 1'b0;
                        IROM_A  <= '0;
                    end
                end
                ST_IDLE: begin
                    if (cmd_valid) begin
                        cmd_r <= cmd;
                        busy  <= 1'b1;
                        if (cmd == CMD_WRITE) begin
                            state      <= ST_WRITE;
                            IRAM_valid <= 1'b1;
                            IRAM_A     <= '0;
                            IRAM_D     <= pix_buf[0];
                        end else begin
                            state <= ST_OP;
                        end
                    end
                end
                ST_OP: begin
                    case (cmd_r)
                        CMD_UP:    if (wy != '0)    wy <= wy - YW'(1);
                        CMD_DOWN:  if (wy < WY_MAX) wy <= wy + YW'(1);
                        CMD_LEFT:  if (wx != '0)    wx <= wx - XW'(1);
                        CMD_RIGHT: if (wx < WX_MAX) wx <= wx + XW'(1);
                        default:   ;
                    endcase
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                ST_WRITE: begin
                    if (IRAM_A == LAST) begin
                        IRAM_valid <= 1'b0;
                        IRAM_A     <= '0;
                        IRAM_D     <= '0;
                        done       <= 1'b1;
                        state      <= ST_DONE;
                    end else begin
                        IRAM_A <= IRAM_A + AW'(1);
                        IRAM_D <= pix_buf[IRAM_A + AW'(1)];
                    end
                end
                ST_DONE: begin
                    // Next frame starts immediately with a re-centred window
                    done    <= 1'b0;
                    state   <= ST_LOAD;
                    IROM_rd <= 1'b1;
                    IROM_A  <= '0;
                    wx      <= WX0;
                    wy      <= WY0;
                end
                default: begin
                    state <= ST_LOAD;
                    busy  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_ctrl_param.sv
// Directed bench for lcd_ctrl_param: default 8x8x8 instance plus a 4x2x4 instance.
module tb_lcd_ctrl_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, reset_s, cmd_valid, clr_ram, use_s;
    logic [3:0] cmd;
    logic [7:0] irom_q, iram_d;
    logic [5:0] irom_a, iram_a;
    logic       irom_rd, iram_valid, busy, done;
    logic [3:0] irom_q_s, iram_d_s;
    logic [2:0] irom_a_s, iram_a_s;
    logic       irom_rd_s, iram_valid_s, busy_s, done_s;

    logic [7:0] rom   [64];
    logic [7:0] ram   [64];
    logic [3:0] rom_s [8];
    logic [3:0] ram_s [8];

    int n_cmp = 0;
    int n_err = 0;
    int n_wr = 0;
    int n_done = 0;
    int wr0, dn0;

    lcd_ctrl_param dut (
        .clk(clk), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid),
        .IROM_Q(irom_q), .IROM_rd(irom_rd), .IROM_A(irom_a),
        .IRAM_valid(iram_valid), .IRAM_D(iram_d), .IRAM_A(iram_a),
        .busy(busy), .done(done)
    );

    lcd_ctrl_param #(.IMG_W(4), .IMG_H(2), .PIX_W(4)) dut_s (
        .clk(clk), .reset(reset_s), .cmd(cmd), .cmd_valid(cmd_valid),
        .IROM_Q(irom_q_s), .IROM_rd(irom_rd_s), .IROM_A(irom_a_s),
        .IRAM_valid(iram_valid_s), .IRAM_D(iram_d_s), .IRAM_A(iram_a_s),
        .busy(busy_s), .done(done_s)
    );

    // ROM answers one cycle after the address; RAM records every write strobe
    always @(posedge clk) begin
        irom_q   <= rom[irom_a];
        irom_q_s <= rom_s[irom_a_s];
        if (clr_ram) begin
            for (int i = 0; i < 64; i++) ram[i] <= 8'hEE;
            for (int i = 0; i < 8; i++)  ram_s[i] <= 4'hA;
        end else begin
            if (iram_valid)   ram[iram_a]     <= iram_d;
            if (iram_valid_s) ram_s[iram_a_s] <= iram_d_s;
        end
        if (iram_valid || iram_valid_s) n_wr <= n_wr + 1;
        if (done || done_s)             n_done <= n_done + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic cur_busy();
        return use_s ? busy_s : busy;
    endfunction

    task automatic issue(input logic [3:0] c);
        cmd       = c;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (cur_busy() && k < 400) begin
            tick();
            k++;
        end
        check(tag, cur_busy(), 0);
    endtask

    task automatic send(input logic [3:0] c);
        issue(c);
        wait_idle("op_idle");
    endtask

    task automatic wr_begin();
        clr_ram = 1'b1;
        tick();
        clr_ram = 1'b0;
        wr0 = n_wr;
        dn0 = n_done;
        issue(4'd0);
    endtask

    task automatic wr_end(input string tag);
        wait_idle({tag, "_idle"});
        check({tag, "_nwr"}, n_wr - wr0, use_s ? 8 : 64);
        check({tag, "_ndone"}, n_done - dn0, 1);
    endtask

    initial begin
        int cnt, ok;
        reset = 1'b0; reset_s = 1'b0; use_s = 1'b0;
        cmd = 4'd0; cmd_valid = 1'b0; clr_ram = 1'b0;
        for (int i = 0; i < 64; i++) rom[i] = 8'(i);
        for (int i = 0; i < 8; i++)  rom_s[i] = 4'd15;
        repeat (3) tick();

        check("rst_rom_rd", irom_rd, 0);
        check("rst_rom_a", irom_a, 0);
        check("rst_ram_valid", iram_valid, 0);
        check("rst_ram_d", iram_d, 0);
        check("rst_ram_a", iram_a, 0);
        check("rst_busy", busy, 1);
        check("rst_done", done, 0);

        reset = 1'b1;
        tick();
        check("load_first_rd", irom_rd, 1);
        check("load_first_a", irom_a, 0);
        tick();
        check("load_second_a", irom_a, 1);
        cnt = 1;
        while (busy && cnt < 200) begin
            tick();
            cnt++;
        end
        check("load_cycles", cnt, 65);
        check("idle_rom_rd", irom_rd, 0);

        // Plain write-out of the loaded frame
        wr_begin();
        wr_end("wr_plain");
        ok = 0;
        for (int i = 0; i < 64; i++) if (ram[i] == 8'(i)) ok++;
        check("plain_all_k", ok, 64);
        check("plain_27", ram[27], 27);

        // Centre window (3,3): 27,28,35,36
        send(4'd7);
        wr_begin();
        wr_end("wr_avg");
        check("avg_a", ram[27], 31);
        check("avg_b", ram[28], 31);
        check("avg_c", ram[35], 31);
        check("avg_d", ram[36], 31);
        check("avg_keep26", ram[26], 26);
        check("avg_keep44", ram[44], 44);

        send(4'd5);
        wr_begin();
        wr_end("wr_max");
        check("max_a", ram[27], 36);
        check("max_d", ram[36], 36);
        check("max_keep37", ram[37], 37);

        // Saturate to top-left, rotate CW
        for (int i = 0; i < 5; i++) send(4'd3);
        for (int i = 0; i < 5; i++) send(4'd1);
        send(4'd9);
        wr_begin();
        wr_end("wr_cw");
        check("cw_0", ram[0], 8);
        check("cw_1", ram[1], 0);
        check("cw_8", ram[8], 9);
        check("cw_9", ram[9], 1);
        check("cw_keep2", ram[2], 2);

        // Saturate to bottom-right (6,6), min
        for (int i = 0; i < 5; i++) send(4'd4);
        for (int i = 0; i < 5; i++) send(4'd2);
        send(4'd6);
        wr_begin();
        wr_end("wr_min");
        check("min_54", ram[54], 54);
        check("min_55", ram[55], 54);
        check("min_62", ram[62], 54);
        check("min_63", ram[63], 54);
        check("min_keep53", ram[53], 53);

        // CCW at (3,3), right, mirror-Y at (4,3), left twice, mirror-X at (2,3)
        send(4'd8);
        send(4'd4);
        send(4'd11);
        send(4'd3);
        send(4'd3);
        send(4'd10);
        wr_begin();
        wr_end("wr_rot");
        check("rot_26", ram[26], 34);
        check("rot_27", ram[27], 27);
        check("rot_28", ram[28], 29);
        check("rot_29", ram[29], 36);
        check("rot_34", ram[34], 26);
        check("rot_35", ram[35], 28);
        check("rot_36", ram[36], 37);
        check("rot_37", ram[37], 35);

        // No-op code, and a write command offered while busy
        cmd = 4'd13;
        cmd_valid = 1'b1;
        tick();
        check("nop_busy", busy, 1);
        cmd = 4'd0;
        tick();
        check("nop_back_idle", busy, 0);
        cmd_valid = 1'b0;
        repeat (3) tick();
        check("ignored_no_write", iram_valid, 0);
        check("ignored_still_idle", busy, 0);
        wr_begin();
        wr_end("wr_nop");
        ok = 0;
        for (int i = 0; i < 64; i++) if (ram[i] == 8'(i)) ok++;
        check("nop_all_k", ok, 64);

        // Reset in the middle of a write-out
        wr_begin();
        cnt = 0;
        while (!(iram_valid && iram_a == 6'd20) && cnt < 100) begin
            tick();
            cnt++;
        end
        check("wr_reach20", iram_a, 20);
        reset = 1'b0;
        #1;
        check("abort_ram_valid", iram_valid, 0);
        check("abort_busy", busy, 1);
        check("abort_ram_a", iram_a, 0);
        tick();
        reset = 1'b1;
        tick();
        check("restart_rd", irom_rd, 1);
        check("restart_a", irom_a, 0);
        check("restart_busy", busy, 1);
        wait_idle("restart_idle");

        // Small 4x2x4 instance, all pixels 15, window at (1,0)
        reset = 1'b0;
        use_s = 1'b1;
        reset_s = 1'b1;
        tick();
        wait_idle("s_load_idle");
        send(4'd7);
        wr_begin();
        for (int i = 0; i < 8; i++) rom_s[i] = 4'(i);
        wr_end("s_wr_avg");
        check("s_avg_1", ram_s[1], 15);
        check("s_avg_6", ram_s[6], 15);
        check("s_keep0", ram_s[0], 15);

        send(4'd2);
        send(4'd5);
        wr_begin();
        wr_end("s_wr_max");
        check("s_max_1", ram_s[1], 6);
        check("s_max_2", ram_s[2], 6);
        check("s_max_5", ram_s[5], 6);
        check("s_max_6", ram_s[6], 6);
        check("s_keep_0", ram_s[0], 0);
        check("s_keep_7", ram_s[7], 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
